// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared SDRAM command encodings and the arbiter state encoding.
// Commands are {cs_n, ras_n, cas_n, we_n}.
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/sdram_arbit_if.sv
// -----------------------------------------------------------------------------
// sdram_arbit_if
// Bundle between the SDRAM command generators (init, auto-refresh, write,
// read) and the central arbiter, plus the SDRAM command/address pins.
//   master : the generator side -- drives requests, end flags, cmd/addr/bank,
//            observes grant pulses, pins and arb_err.
//   slave  : the arbiter -- consumes requests, drives grants, pins, arb_err.
// -----------------------------------------------------------------------------
interface sdram_arbit_if #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
) ();

    // init generator
    logic              flag_init_end;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;
    // auto-refresh generator
    logic              ref_req;
    logic              ref_en;
    logic              flag_ref_end;
    logic [3:0]        aref_cmd;
    logic [ADDR_W-1:0] aref_addr;
    // write generator
    logic              wr_req;
    logic              wr_en;
    logic              flag_wr_end;
    logic [3:0]        wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [BA_W-1:0]   wr_ba;
    // read generator
    logic              rd_req;
    logic              rd_en;
    logic              flag_rd_end;
    logic [3:0]        rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic [BA_W-1:0]   rd_ba;
    // SDRAM pins
    logic              sdram_cs_n;
    logic              sdram_ras_n;
    logic              sdram_cas_n;
    logic              sdram_we_n;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BA_W-1:0]   sdram_ba;
    // watchdog abort
    logic              arb_err;

    modport master (
        output flag_init_end, init_cmd, init_addr,
        output ref_req, flag_ref_end, aref_cmd, aref_addr,
        output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_ba,
        output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_ba,
        input  ref_en, wr_en, rd_en,
        input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_addr, sdram_ba, arb_err
    );

    modport slave (
        input  flag_init_end, init_cmd, init_addr,
        input  ref_req, flag_ref_end, aref_cmd, aref_addr,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_ba,
        input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_ba,
        output ref_en, wr_en, rd_en,
        output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_addr, sdram_ba, arb_err
    );

endinterface

// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
// Central SDRAM command arbiter. Grants one command generator at a time
// (priority refresh > write > read), announces the grant with a one-cycle
// registered *_en pulse and routes that generator's cmd/addr/bank to the pins
// until its end flag. Grants are never pre-empted.
//
// Ports:
//   sclk   system clock
//   reset  asynchronous reset, active-low
//   bus    sdram_arbit_if.slave: requests, end flags, per-client cmd/addr/bank,
//          grant pulses, SDRAM command/address/bank pins, arb_err
//
// Parameters: ADDR_W (address width), BA_W (bank width), TIMEOUT (watchdog
// limit in sclk cycles, 1..256).
//
// Build option: define SDRAM_ARBIT_WDOG_EN to enable the grant watchdog. It
// aborts a grant that has lasted TIMEOUT cycles without its end flag, returns
// to ARBIT and pulses arb_err. Without it arb_err is tied low and grants are
// held indefinitely.
// -----------------------------------------------------------------------------
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int BA_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic          sclk,
    input  logic          reset,
    sdram_arbit_if.slave  bus
);

    arb_state_e state_q, state_d;
    logic       ref_en_q, ref_en_d;
    logic       wr_en_q,  wr_en_d;
    logic       rd_en_q,  rd_en_d;
    logic       arb_err_q, arb_err_d;
    logic       end_hit;

    // End flag belonging to the grant currently held; flags of other clients
    // are ignored.
    always_comb begin
        end_hit = 1'b0;
        case (state_q)
            AREF:    end_hit = bus.flag_ref_end;
            WRITE:   end_hit = bus.flag_wr_end;
            READ:    end_hit = bus.flag_rd_end;
            default: end_hit = 1'b0;
        endcase
    end

`ifdef SDRAM_ARBIT_WDOG_EN
    logic [7:0] cnt_q, cnt_d;
    logic       wdog_hit;

    // The counter holds k during the k-th cycle (0-based) of a grant, so the
    // abort fires after exactly TIMEOUT cycles in the grant state.
    assign wdog_hit = (cnt_q == 8'(TIMEOUT - 1));
`else
    wire unused_timeout = (TIMEOUT > 0);
`endif

    always_comb begin
        state_d   = state_q;
        ref_en_d  = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        arb_err_d = 1'b0;
`ifdef SDRAM_ARBIT_WDOG_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.flag_init_end) state_d = ARBIT;
            end
            ARBIT: begin
`ifdef SDRAM_ARBIT_WDOG_EN
                cnt_d = 8'd0;
`endif
                if (bus.ref_req) begin
                    state_d  = AREF;
                    ref_en_d = 1'b1;
                end else if (bus.wr_req) begin
                    state_d  = WRITE;
                    wr_en_d  = 1'b1;
                end else if (bus.rd_req) begin
                    state_d  = READ;
                    rd_en_d  = 1'b1;
                end
            end
            AREF, WRITE, READ: begin
                if (end_hit) begin
                    state_d = ARBIT;
                end
`ifdef SDRAM_ARBIT_WDOG_EN
                else if (wdog_hit) begin
                    state_d   = ARBIT;
                    arb_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ref_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            arb_err_q <= 1'b0;
`ifdef SDRAM_ARBIT_WDOG_EN
            cnt_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            ref_en_q  <= ref_en_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            arb_err_q <= arb_err_d;
`ifdef SDRAM_ARBIT_WDOG_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Pin mux follows the state register directly so a reset shows init_cmd
    // on the pins without waiting for a clock edge.
    logic [3:0]        cmd_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [BA_W-1:0]   ba_mux;

    always_comb begin
        cmd_mux  = CMD_NOP;
        addr_mux = '0;
        ba_mux   = '0;
        case (state_q)
            IDLE: begin
                cmd_mux  = bus.init_cmd;
                addr_mux = bus.init_addr;
            end
            AREF: begin
                cmd_mux  = bus.aref_cmd;
                addr_mux = bus.aref_addr;
            end
            WRITE: begin
                cmd_mux  = bus.wr_cmd;
                addr_mux = bus.wr_addr;
                ba_mux   = bus.wr_ba;
            end
            READ: begin
                cmd_mux  = bus.rd_cmd;
                addr_mux = bus.rd_addr;
                ba_mux   = bus.rd_ba;
            end
            default: begin
                cmd_mux  = CMD_NOP;
                addr_mux = '0;
                ba_mux   = '0;
            end
        endcase
    end

    assign bus.sdram_cs_n  = cmd_mux[3];
    assign bus.sdram_ras_n = cmd_mux[2];
    assign bus.sdram_cas_n = cmd_mux[1];
    assign bus.sdram_we_n  = cmd_mux[0];
    assign bus.sdram_addr  = addr_mux;
    assign bus.sdram_ba    = ba_mux;
    assign bus.ref_en      = ref_en_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.arb_err     = arb_err_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbit
// Directed vectors for sdram_arbit: a per-cycle table of client inputs and
// expected pins/grant pulses, followed by hand-written sequences for an
// asynchronous reset in the middle of a read and for grant holding (watchdog
// abort when SDRAM_ARBIT_WDOG_EN is defined).
// -----------------------------------------------------------------------------
module tb_sdram_arbit;

    localparam int ADDR_W  = 13;
    localparam int BA_W    = 2;
    localparam int TIMEOUT = 64;

    // expected pin sets
    localparam int K_INIT = 0;
    localparam int K_NOP  = 1;
    localparam int K_AREF = 2;
    localparam int K_WR   = 3;
    localparam int K_RD   = 4;

    logic sclk  = 1'b0;
    logic reset = 1'b0;

    int checks   = 0;
    int failures = 0;

    sdram_arbit_if #(.ADDR_W(ADDR_W), .BA_W(BA_W)) bus ();

    sdram_arbit #(
        .ADDR_W (ADDR_W),
        .BA_W   (BA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .sclk (sclk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 sclk = ~sclk;

    // inputs packed as {init_end, ref_req, wr_req, rd_req, ref_end, wr_end, rd_end}
    typedef struct {
        logic [6:0] in;
        int         kind;
        logic [2:0] en;     // {ref_en, wr_en, rd_en}
    } vec_t;

    vec_t vecs [24];

    task automatic drive(input logic [6:0] in);
        bus.flag_init_end = in[6];
        bus.ref_req       = in[5];
        bus.wr_req        = in[4];
        bus.rd_req        = in[3];
        bus.flag_ref_end  = in[2];
        bus.flag_wr_end   = in[1];
        bus.flag_rd_end   = in[0];
    endtask

    task automatic chk(input string nm, input int idx, input int kind,
                       input logic [2:0] en, input logic err);
        logic [3:0]        e_cmd;
        logic [ADDR_W-1:0] e_addr;
        logic [BA_W-1:0]   e_ba;
        logic [22:0]       exp_v, act_v;
        case (kind)
            K_INIT:  begin e_cmd = 4'b0010; e_addr = 13'h0033; e_ba = 2'd0; end
            K_AREF:  begin e_cmd = 4'b0001; e_addr = 13'h0400; e_ba = 2'd0; end
            K_WR:    begin e_cmd = 4'b0100; e_addr = 13'h0123; e_ba = 2'd2; end
            K_RD:    begin e_cmd = 4'b0101; e_addr = 13'h0456; e_ba = 2'd1; end
            default: begin e_cmd = 4'b0111; e_addr = 13'h0000; e_ba = 2'd0; end
        endcase
        exp_v = {e_cmd, e_addr, e_ba, en, err};
        act_v = {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                 bus.sdram_addr, bus.sdram_ba, bus.ref_en, bus.wr_en, bus.rd_en,
                 bus.arb_err};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s[%0d] got cmd=%b addr=%h ba=%0d en=%b err=%b, want cmd=%b addr=%h ba=%0d en=%b err=%b",
                     nm, idx, act_v[22:19], act_v[18:6], act_v[5:4], act_v[3:1], act_v[0],
                     e_cmd, e_addr, e_ba, en, err);
        end else begin
            $display("check %s[%0d] cmd=%b addr=%h ba=%0d en=%b err=%b ok",
                     nm, idx, act_v[22:19], act_v[18:6], act_v[5:4], act_v[3:1], act_v[0]);
        end
    endtask

    initial begin
        // per-cycle table: inputs during the cycle, outputs expected during it
        vecs[0]  = '{7'b0000000, K_INIT, 3'b000};
        vecs[1]  = '{7'b0000000, K_INIT, 3'b000};
        vecs[2]  = '{7'b1000000, K_INIT, 3'b000};  // init done
        vecs[3]  = '{7'b1100000, K_NOP,  3'b000};  // refresh request
        vecs[4]  = '{7'b1000000, K_AREF, 3'b100};  // ref_en pulse
        vecs[5]  = '{7'b1000100, K_AREF, 3'b000};  // refresh end
        vecs[6]  = '{7'b1000000, K_NOP,  3'b000};
        vecs[7]  = '{7'b1111000, K_NOP,  3'b000};  // all three request
        vecs[8]  = '{7'b1011100, K_AREF, 3'b100};
        vecs[9]  = '{7'b1011000, K_NOP,  3'b000};
        vecs[10] = '{7'b1001001, K_WR,   3'b010};  // stray rd_end ignored
        vecs[11] = '{7'b1001010, K_WR,   3'b000};
        vecs[12] = '{7'b1001000, K_NOP,  3'b000};
        vecs[13] = '{7'b1000000, K_RD,   3'b001};
        vecs[14] = '{7'b1000001, K_RD,   3'b000};
        vecs[15] = '{7'b1010000, K_NOP,  3'b000};
        vecs[16] = '{7'b1100000, K_WR,   3'b010};  // refresh arrives mid-write
        vecs[17] = '{7'b0100100, K_WR,   3'b000};  // init_end falls, stray ref_end
        vecs[18] = '{7'b0100010, K_WR,   3'b000};
        vecs[19] = '{7'b0100000, K_NOP,  3'b000};
        vecs[20] = '{7'b0000100, K_AREF, 3'b100};
        vecs[21] = '{7'b0001000, K_NOP,  3'b000};
        vecs[22] = '{7'b0000000, K_RD,   3'b001};
        vecs[23] = '{7'b0000000, K_RD,   3'b000};

        bus.init_cmd  = 4'b0010;  bus.init_addr = 13'h0033;
        bus.aref_cmd  = 4'b0001;  bus.aref_addr = 13'h0400;
        bus.wr_cmd    = 4'b0100;  bus.wr_addr   = 13'h0123; bus.wr_ba = 2'd2;
        bus.rd_cmd    = 4'b0101;  bus.rd_addr   = 13'h0456; bus.rd_ba = 2'd1;
        drive(7'b0000000);

        // reset state
        repeat (2) @(negedge sclk);
        #1 chk("reset", 0, K_INIT, 3'b000, 1'b0);
        @(negedge sclk);
        reset = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge sclk);
            drive(vecs[i].in);
            #1 chk("row", i, vecs[i].kind, vecs[i].en, 1'b0);
        end

        // asynchronous reset while in READ
        @(negedge sclk);
        drive(7'b0001000);
        reset = 1'b0;
        #1 chk("rst_async", 0, K_INIT, 3'b000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge sclk);
            #1 chk("rst_hold", i, K_INIT, 3'b000, 1'b0);
        end
        @(negedge sclk);
        reset = 1'b1;
        #1 chk("rst_rel", 0, K_INIT, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge sclk);
            #1 chk("idle_wait", i, K_INIT, 3'b000, 1'b0);
        end
        @(negedge sclk);
        drive(7'b1001000);
        #1 chk("init_again", 0, K_INIT, 3'b000, 1'b0);
        @(negedge sclk);
        #1 chk("post_init", 0, K_NOP, 3'b000, 1'b0);
        @(negedge sclk);
        drive(7'b1000000);
        #1 chk("rd_grant", 0, K_RD, 3'b001, 1'b0);
        @(negedge sclk);
        drive(7'b1000001);
        #1 chk("rd_end", 0, K_RD, 3'b000, 1'b0);
        @(negedge sclk);
        drive(7'b1010000);
        #1 chk("arb_nop", 0, K_NOP, 3'b000, 1'b0);
        @(negedge sclk);
        drive(7'b1000000);
        #1 chk("wr_grant", 0, K_WR, 3'b010, 1'b0);

`ifdef SDRAM_ARBIT_WDOG_EN
        begin
            int wr_cycles;
            wr_cycles = 1;
            for (int i = 0; i < 300; i++) begin
                @(negedge sclk);
                #1;
                if ({bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} != 4'b0100)
                    break;
                wr_cycles++;
            end
            checks++;
            if (wr_cycles != TIMEOUT) begin
                failures++;
                $display("FAIL wdog_len got %0d cycles in WRITE, want %0d", wr_cycles, TIMEOUT);
            end else begin
                $display("check wdog_len cycles=%0d ok", wr_cycles);
            end
            chk("wdog_err", 0, K_NOP, 3'b000, 1'b1);
            @(negedge sclk);
            #1 chk("wdog_after", 0, K_NOP, 3'b000, 1'b0);
        end
`else
        begin
            int held;
            held = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge sclk);
                #1;
                if ({bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} == 4'b0100
                    && bus.arb_err == 1'b0)
                    held++;
            end
            checks++;
            if (held != 100) begin
                failures++;
                $display("FAIL grant_hold got %0d of 100 cycles in WRITE, want 100", held);
            end else begin
                $display("check grant_hold cycles=%0d ok", held);
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
